output_synchronizer_rr: RTL



---
 rtl/output_synchronizer_rr.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/output_synchronizer_rr.sv
// output_synchronizer_rr
// Chooses the word that drives the node output link. Candidates are the ready
// peripheral words, picked round-robin, and the scheduler's next_task.
// The chosen word is held in a register under a valid/ready handshake. The
// peripheral that supplied an accepted word gets a one-hot acknowledge.
// A starvation guard stops busy peripherals from locking out a pending task.
module output_synchronizer_rr #(
   parameter int NUM_PERIPH   = 4,
   parameter int DATA_W       = 16,
   parameter int TASK_W       = 8,
   parameter int STATUS_LSB   = 8,
   parameter int STATUS_W     = 4,
   parameter int READY_CODE   = 1,
   parameter int STARVE_LIMIT = 3,
   localparam int SRC_W       = $clog2(NUM_PERIPH + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [TASK_W-1:0]            next_task,
   input  logic                         next_task_valid,
   input  logic [NUM_PERIPH*DATA_W-1:0] periph_data,
   output logic [NUM_PERIPH-1:0]        periph_ack,
   output logic [DATA_W-1:0]            out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SRC_W-1:0]             out_src
);

   // Pointer width must stay at least one bit, even with a single channel.
   localparam int PTR_W    = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [SRC_W-1:0]    TASK_SRC  = SRC_W'(NUM_PERIPH);
   localparam logic [PTR_W-1:0]    PTR_RESET = PTR_W'(NUM_PERIPH - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // A channel is ready only when its status field equals READY_CODE.
   // Every other bit of the word is ignored for this test.
   function automatic logic word_is_ready(input logic [DATA_W-1:0] word);
      return (word[STATUS_LSB +: STATUS_W] == STATUS_W'(READY_CODE));
   endfunction

   // Descending round-robin search that starts at ptr and wraps from 0 to
   // NUM_PERIPH-1. The result MSB is a found flag. The low bits hold the
   // winning channel.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_PERIPH-1:0] rdy,
                                              input logic [PTR_W-1:0]      ptr);
      logic [PTR_W:0] res;
      int             cand;
      res = {1'b0, {PTR_W{1'b0}}};
      for (int k = 0; k < NUM_PERIPH; k++) begin
         cand = int'(ptr) - k;
         if (cand < 0) begin
            cand = cand + NUM_PERIPH;
         end else begin
            cand = cand;
         end
         if (!res[PTR_W] && rdy[cand[PTR_W-1:0]]) begin
            res = {1'b1, cand[PTR_W-1:0]};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // After a peripheral word is accepted, the next search starts just below
   // the channel that won. The value wraps modulo NUM_PERIPH.
   function automatic logic [PTR_W-1:0] ptr_after(input logic [SRC_W-1:0] src);
      if (src == {SRC_W{1'b0}}) begin
         return PTR_RESET;
      end else begin
         return PTR_W'(src - SRC_W'(1));
      end
   endfunction

   state_t                  state_q, state_d;
   logic [DATA_W-1:0]       out_q, out_d;
   logic                    out_valid_q, out_valid_d;
   logic [SRC_W-1:0]        out_src_q, out_src_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [STARVE_W-1:0]     starve_q, starve_d;

   logic [NUM_PERIPH-1:0]   ready_s;
   logic [PTR_W:0]          pick_s;
   logic                    grant_found_s;
   logic [PTR_W-1:0]        grant_idx_s;
   logic [DATA_W-1:0]       grant_word_s;
   logic [DATA_W-1:0]       task_word_s;
   logic                    starve_hit_s;
   logic [NUM_PERIPH-1:0]   periph_ack_s;

   // Build the per-channel ready vector from the status fields.
   always_comb begin
      ready_s = {NUM_PERIPH{1'b0}};
      for (int i = 0; i < NUM_PERIPH; i++) begin
         ready_s[i] = word_is_ready(periph_data[i*DATA_W +: DATA_W]);
      end
   end

   // Find the round-robin winner and gather the candidate words.
   always_comb begin
      pick_s        = rr_pick(ready_s, ptr_q);
      grant_found_s = pick_s[PTR_W];
      grant_idx_s   = pick_s[PTR_W-1:0];
      grant_word_s  = periph_data[int'(grant_idx_s)*DATA_W +: DATA_W];
      task_word_s   = DATA_W'(next_task);
      starve_hit_s  = (starve_q == STARVE_MAX) && next_task_valid;
   end

   // Next-state logic: choose in IDLE, hold until the handshake in HOLD.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      starve_d    = starve_q;
      case (state_q)
         ST_IDLE: begin
            if (starve_hit_s) begin
               // A pending task has waited through STARVE_LIMIT grants, so it
               // goes ahead of the ready peripherals.
               out_d       = task_word_s;
               out_src_d   = TASK_SRC;
               out_valid_d = 1'b1;
               starve_d    = {STARVE_W{1'b0}};
               state_d     = ST_HOLD;
            end else if (grant_found_s) begin
               out_d       = grant_word_s;
               out_src_d   = SRC_W'(grant_idx_s);
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
               if (!next_task_valid) begin
                  starve_d = {STARVE_W{1'b0}};
               end else if (starve_q == STARVE_MAX) begin
                  starve_d = starve_q;
               end else begin
                  starve_d = starve_q + STARVE_W'(1);
               end
            end else if (next_task_valid) begin
               out_d       = task_word_s;
               out_src_d   = TASK_SRC;
               out_valid_d = 1'b1;
               starve_d    = {STARVE_W{1'b0}};
               state_d     = ST_HOLD;
            end else begin
               // Nothing to send. out keeps its last value.
               out_valid_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
               if (out_src_q < TASK_SRC) begin
                  ptr_d = ptr_after(out_src_q);
               end else begin
                  // An accepted task does not move the pointer.
                  ptr_d = ptr_q;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_q       <= {DATA_W{1'b0}};
         out_valid_q <= 1'b0;
         out_src_q   <= {SRC_W{1'b0}};
         ptr_q       <= PTR_RESET;
         starve_q    <= {STARVE_W{1'b0}};
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
         starve_q    <= starve_d;
      end
   end

   // The acknowledge pulses in the accept cycle of a peripheral word.
   // It is held off while reset is asserted, because reset discards the word.
   always_comb begin
      periph_ack_s = {NUM_PERIPH{1'b0}};
      for (int i = 0; i < NUM_PERIPH; i++) begin
         if (rst_n && (state_q == ST_HOLD) && out_valid_q && out_ready &&
             (out_src_q == SRC_W'(i))) begin
            periph_ack_s[i] = 1'b1;
         end else begin
            periph_ack_s[i] = 1'b0;
         end
      end
   end

   assign periph_ack = periph_ack_s;
   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign out_src    = out_src_q;

endmodule
